// File: rtl/imem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter_if
// Description : Bundle of the fetch port, the loader port and the single-port
//               instruction-memory port of imem_arbiter.
//               slave  : arbiter view. Requests and mem_rdata are inputs.
//                        Grants, responses and memory strobes are outputs.
//               master : environment view (fetch unit, loader, memory).
//                        Every direction is the opposite of slave.
//               Ports grouped here:
//                 f_req, f_addr[31:0], f_flush, f_gnt, f_valid, f_instr[31:0]
//                 l_req, l_we, l_addr[31:0], l_wdata[31:0], l_gnt, l_valid,
//                 l_rdata[31:0]
//                 mem_en, mem_we, mem_addr[log2(MEM_WORDS)-1:0],
//                 mem_wdata[31:0], mem_rdata[31:0]
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_arbiter_if #(
    parameter int MEM_WORDS = 2048
);
    localparam int c_addr_w = $clog2(MEM_WORDS);

    // fetch port
    logic                f_req;
    logic [31:0]         f_addr;
    logic                f_flush;
    logic                f_gnt;
    logic                f_valid;
    logic [31:0]         f_instr;
    // loader port
    logic                l_req;
    logic                l_we;
    logic [31:0]         l_addr;
    logic [31:0]         l_wdata;
    logic                l_gnt;
    logic                l_valid;
    logic [31:0]         l_rdata;
    // memory port
    logic                mem_en;
    logic                mem_we;
    logic [c_addr_w-1:0] mem_addr;
    logic [31:0]         mem_wdata;
    logic [31:0]         mem_rdata;

    modport slave (
        input  f_req, f_addr, f_flush,
        input  l_req, l_we, l_addr, l_wdata,
        input  mem_rdata,
        output f_gnt, f_valid, f_instr,
        output l_gnt, l_valid, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output f_req, f_addr, f_flush,
        output l_req, l_we, l_addr, l_wdata,
        output mem_rdata,
        input  f_gnt, f_valid, f_instr,
        input  l_gnt, l_valid, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_arbiter
// Description : Shares one single-port instruction memory between the
//               instruction fetch unit and a loader.
//               - Fixed priority: loader before fetch.
//               - One access is issued per cycle.
//               - Read data comes back one cycle after the grant.
//               - The response goes to whichever requester owned the access.
//               Optional feature: define IMEM_ARB_STARVE_GUARD_EN to enable
//               the starvation guard. The loader then gives way to fetch
//               after STARVE_MAX consecutive loader grants taken while fetch
//               was waiting.
// Ports       : clk        - clock
//               rst        - synchronous, active-high reset
//               bus.slave  - fetch, loader and memory signals
//                            (see imem_arbiter_if)
// Parameters  : MEM_WORDS  - memory depth in 32-bit words (power of two)
//               STARVE_MAX - loader grants tolerated while fetch waits
// Revision    : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int MEM_WORDS  = 2048,
    parameter int STARVE_MAX = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    imem_arbiter_if.slave  bus
);
    localparam int          c_addr_w = $clog2(MEM_WORDS);
    localparam logic [31:0] c_nop    = 32'h0000_0013;

    // Records who the access issued last cycle belongs to.
    // A loader write produces no response, so it records OWN_NONE.
    typedef enum logic [1:0] {
        OWN_NONE    = 2'd0,
        OWN_FETCH   = 2'd1,
        OWN_LOAD_RD = 2'd2
    } owner_t;

    owner_t      r_owner;
    owner_t      w_owner_next;
    logic        w_f_gnt;
    logic        w_l_gnt;
    logic        w_fetch_override;
    logic [31:0] w_addr;
    logic        w_f_valid;
    logic        w_l_valid;
    logic [31:0] w_f_instr;
    logic [31:0] w_l_rdata;
    logic [31:0] r_f_instr;
    logic [31:0] r_l_rdata;

`ifdef IMEM_ARB_STARVE_GUARD_EN
    localparam int                 c_cnt_w      = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_MAX);

    logic [c_cnt_w-1:0] r_starve;

    // Fetch wins a contested cycle once the loader has used its quota.
    assign w_fetch_override = bus.f_req && bus.l_req && (r_starve == c_starve_max);

    // Counts loader grants taken while fetch keeps asking.
    // Any fetch grant, or fetch going idle, starts the count again.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (w_f_gnt || !bus.f_req) begin
            r_starve <= '0;
        end else if (w_l_gnt && (r_starve != c_starve_max)) begin
            r_starve <= r_starve + 1'b1;
        end
    end
`else
    localparam int c_unused_starve_max = STARVE_MAX;

    assign w_fetch_override = 1'b0;
`endif

    // Grant decision. It is combinational so the access issues in the same
    // cycle as the request. Reset masks every grant.
    always_comb begin
        w_f_gnt = 1'b0;
        w_l_gnt = 1'b0;
        if (!rst) begin
            if (bus.l_req && !w_fetch_override) begin
                w_l_gnt = 1'b1;
            end else if (bus.f_req) begin
                w_f_gnt = 1'b1;
            end
        end
    end

    assign w_addr        = w_l_gnt ? bus.l_addr : bus.f_addr;
    assign bus.f_gnt     = w_f_gnt;
    assign bus.l_gnt     = w_l_gnt;
    assign bus.mem_en    = w_f_gnt | w_l_gnt;
    assign bus.mem_we    = w_l_gnt & bus.l_we;
    // Byte address to word index. Bits above the memory size wrap around.
    assign bus.mem_addr  = w_addr[c_addr_w+1:2];
    assign bus.mem_wdata = bus.l_wdata;

    logic [31:0] w_unused_addr_bits;
    assign w_unused_addr_bits = w_addr;

    // Owner tracking: next-state logic, then the state register.
    always_comb begin
        w_owner_next = OWN_NONE;
        if (w_f_gnt) begin
            w_owner_next = OWN_FETCH;
        end else if (w_l_gnt && !bus.l_we) begin
            w_owner_next = OWN_LOAD_RD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_next;
        end
    end

    // Responses. mem_rdata is live during the cycle after the grant.
    // It is passed straight through, so the response costs no extra cycle.
    // Gating with rst discards an access issued just before reset.
    assign w_f_valid = !rst && (r_owner == OWN_FETCH);
    assign w_l_valid = !rst && (r_owner == OWN_LOAD_RD);

    always_comb begin
        w_f_instr = r_f_instr;
        w_l_rdata = r_l_rdata;
        if (rst) begin
            w_f_instr = '0;
            w_l_rdata = '0;
        end else begin
            if (w_f_valid) begin
                w_f_instr = bus.f_flush ? c_nop : bus.mem_rdata;
            end
            if (w_l_valid) begin
                w_l_rdata = bus.mem_rdata;
            end
        end
    end

    // Hold registers: keep the last delivered values while valid is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_instr <= '0;
            r_l_rdata <= '0;
        end else begin
            if (w_f_valid) begin
                r_f_instr <= w_f_instr;
            end
            if (w_l_valid) begin
                r_l_rdata <= w_l_rdata;
            end
        end
    end

    assign bus.f_valid = w_f_valid;
    assign bus.l_valid = w_l_valid;
    assign bus.f_instr = w_f_instr;
    assign bus.l_rdata = w_l_rdata;
endmodule
`default_nettype wire

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 2048, instruction memory depth in 32-bit words (power of two).
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive loader grants tolerated while fetch waits.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port f_req  input  1  fetch requests an instruction read.
REQ-006 SHALL have port f_addr  input  32  fetch byte address.
REQ-007 SHALL have port f_flush  input  1  squash the fetch response in the current cycle.
REQ-008 SHALL have port f_gnt / f_valid  output  1 / 1  fetch access issued / fetch data valid.
REQ-009 SHALL have port f_instr  output  32  fetched instruction.
REQ-010 SHALL have port l_req / l_we  input  1 / 1  loader access request / write (1) or read (0).
REQ-011 SHALL have port l_addr / l_wdata  input  32 / 32  loader byte address / write data.
REQ-012 SHALL have port l_gnt / l_valid  output  1 / 1  loader access issued / loader read data valid.
REQ-013 SHALL have port l_rdata  output  32  loader read data.
REQ-014 SHALL have port mem_en / mem_we  output  1 / 1  memory access strobe / write strobe.
REQ-015 SHALL have port mem_addr  output  log2(MEM_WORDS)  word index.
REQ-016 SHALL have port mem_wdata / mem_rdata  output 32 / input 32  memory write data / read data (one cycle after mem_en).

Function
REQ-017 SHALL arbitrate the single-port memory between fetch and loader each cycle; at most one of f_gnt, l_gnt high per cycle.
REQ-018 SHALL, when both request, grant the loader (fixed priority loader > fetch), subject to REQ-026.
REQ-019 SHALL drive f_gnt, l_gnt, mem_en, mem_we, mem_addr, mem_wdata combinationally in the grant cycle; mem_we = l_gnt & l_we.
REQ-020 SHALL form mem_addr = addr[log2(MEM_WORDS)+1:2]; upper bits ignored (wrap modulo MEM_WORDS); addr[1:0] ignored.
REQ-021 SHALL register the owner (NONE, FETCH, LOAD_RD) of each issued access; a loader write records NONE.
REQ-022 SHALL, one cycle after a fetch grant, assert f_valid for exactly one cycle with f_instr = mem_rdata.
REQ-023 SHALL, if f_flush is high in that response cycle, still assert f_valid but drive f_instr = 32'h00000013 (NOP).
REQ-024 SHALL, one cycle after a loader read grant, assert l_valid for one cycle with l_rdata = mem_rdata; no l_valid for writes.
REQ-025 SHALL hold f_instr and l_rdata at their last values when the corresponding valid is low.
REQ-026 SHALL maintain a starvation counter 0..STARVE_MAX: increment on each l_gnt while f_req is high; clear on f_gnt or when f_req is low.
REQ-027 SHALL sustain back-to-back grants (one access per cycle, full throughput) with no idle cycles.

Reset
REQ-028 SHALL on rst clear owner to NONE, starvation counter to 0, f_valid, l_valid, f_instr and l_rdata to 0.
REQ-029 SHALL force f_gnt, l_gnt, mem_en, mem_we low in any cycle rst is high.
REQ-030 SHALL discard an access issued the cycle before rst: no valid asserted in the cycle following rst.

Configuration
REQ-031 SHALL, with IMEM_ARB_STARVE_GUARD_EN defined, grant fetch instead of loader when both request and the counter equals STARVE_MAX, then clear the counter.
REQ-032 SHALL, without IMEM_ARB_STARVE_GUARD_EN, apply strict loader priority; counter logic absent, loader may starve fetch indefinitely.

Verification
REQ-033 SHALL cover: mem word 5 = 32'hDEADBEEF, f_req with f_addr=0x14 -> f_gnt same cycle, mem_addr=5, next cycle f_valid=1, f_instr=32'hDEADBEEF.
REQ-034 SHALL cover: same fetch with f_flush=1 in response cycle -> f_valid=1, f_instr=32'h00000013.
REQ-035 SHALL cover: loader write l_addr=0x2000, l_wdata=0x12345678 (MEM_WORDS=2048) -> mem_addr=0, mem_we=1; later loader read of 0x0 -> l_valid=1, l_rdata=0x12345678.
REQ-036 SHALL cover: f_req and l_req held high 10 cycles, guard enabled, STARVE_MAX=4 -> grant pattern L,L,L,L,F repeated; guard disabled -> all L.
REQ-037 SHALL cover: fetch granted, rst high next cycle -> f_valid=0, f_instr=0, no grants during rst.
REQ-038 SHALL cover: alternating f_req-only / l_req read-only every cycle -> one valid per cycle routed to the correct requester, never both.
